dmem_responder: RTL and testbench

Multi-cycle data-memory responder that services the pipeline's MEM-stage load/store requests (memread/memwrite, address, store data). It replaces the single-cycle data memory with a latency-modelled, handshaked target. It stalls the pipeline while an access is in flight, returns load data with a one-cycle acknowledge, and flags misaligned or out-of-range accesses.

---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for MEM-stage loads/stores
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        mem [DEPTH];

    logic req;
    logic acc_err;
    logic accept;
    logic finish;

    assign req     = memread_i | memwrite_i;
    assign acc_err = (memread_i & memwrite_i)
                   | (addr_i[1:0] != 2'b00)
                   | ({2'b00, addr_i[31:2]} >= 32'(DEPTH));
    assign accept  = (state_q == IDLE) && req;
    assign finish  = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Combinational so the pipeline freezes in the same cycle the request appears
                stall_o = req;
                if (req) begin
                    if (acc_err) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_wr_q <= memwrite_i;
                idx_q   <= addr_i[IDX_W+1:2];
                wdata_q <= data_i;
                err_q   <= acc_err;
            end
            if (finish && !op_wr_q) begin
                data_o <= mem[idx_q];
            end
        end
    end

    // Storage is never reset; a reset mid-access forces IDLE so the pending write cannot commit
    always_ff @(posedge clk_i) begin
        if (finish && op_wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ack_o = (state_q == DONE);
    assign err_o = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table-driven self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        memread_i;
    logic        memwrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dmem_responder #(.DEPTH(256), .LATENCY(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .memread_i  (memread_i),
        .memwrite_i (memwrite_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .stall_o    (stall_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one request from cycle 0 until ack; lat is the cycle index of ack (-1 on timeout)
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int stalls, output logic e,
                          output logic [31:0] dout, output int ack_cyc);
        memread_i  = rd;
        memwrite_i = wr;
        addr_i     = a;
        data_i     = d;
        lat = -1; stalls = 0; e = 1'bx; dout = 'x; ack_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (stall_o) stalls++;
            if (ack_o) begin
                lat = k; e = err_o; dout = data_o; ack_cyc = cyc;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
    endtask

    int          lat, stalls, c1, c2;
    logic        e;
    logic [31:0] dout;
    logic        seen_ack;

    initial begin
        //           rd    wr    addr          wdata         err  lat data_o
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 5, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 5, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 5, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0000, 1'b0, 5, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0BAD, 1'b1, 1, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 5, 32'hCAFE_0000};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 1'b0, 5, 32'h1234_5678};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 5, 32'h1234_5678};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 5, 32'hA5A5_A5A5};

        rst_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0; addr_i = '0; data_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_data", data_o, 32'h0);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_stall_idle", 32'(stall_o), 32'h0);
        memread_i = 1'b1;
        #1;
        chk("rst_stall_req", 32'(stall_o), 32'h1);
        memread_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 11; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, stalls, e, dout, c1);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_data", i), dout, vecs[i].exp_data);
            chk($sformatf("v%0d_ack_pulse", i), 32'(ack_o), 32'h0);
        end

        // Back-to-back: read issued in the cycle right after the write's DONE
        access(1'b0, 1'b1, 32'h0, 32'h1, lat, stalls, e, dout, c1);
        access(1'b1, 1'b0, 32'h0, 32'h0, lat, stalls, e, dout, c2);
        chk("b2b_spacing", 32'(c2 - c1), 32'd6);
        chk("b2b_data", dout, 32'h1);
        chk("b2b_err", 32'(e), 32'h0);

        // Request dropped after acceptance still completes the latched read
        memread_i = 1'b1; addr_i = 32'h10;
        @(posedge clk_i); #1;
        memread_i = 1'b0; addr_i = 32'h13;
        lat = -1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk_i);
            if (ack_o) begin
                lat = k; dout = data_o; e = err_o;
                break;
            end
        end
        @(posedge clk_i); #1;
        chk("drop_lat", 32'(lat), 32'd5);
        chk("drop_data", dout, 32'hDEAD_BEEF);
        chk("drop_err", 32'(e), 32'h0);

        // Reset during BUSY aborts the write
        access(1'b0, 1'b1, 32'h8, 32'h77, lat, stalls, e, dout, c1);
        memwrite_i = 1'b1; addr_i = 32'h8; data_i = 32'h55;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        memwrite_i = 1'b0;
        seen_ack = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            seen_ack |= ack_o;
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (8) begin
            @(negedge clk_i);
            seen_ack |= ack_o;
        end
        chk("rstmid_no_ack", 32'(seen_ack), 32'h0);
        chk("rstmid_stall", 32'(stall_o), 32'h0);
        chk("rstmid_data", data_o, 32'h0);
        @(posedge clk_i); #1;
        access(1'b1, 1'b0, 32'h8, 32'h0, lat, stalls, e, dout, c1);
        chk("rstmid_read_lat", 32'(lat), 32'd5);
        chk("rstmid_read_data", dout, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
